// File: rtl/io_bus_master.sv
// -----------------------------------------------------------------------------
// io_bus_master
//
// Initiator end of the expansion IO bus. Turns one single-beat read or write
// request from the core into the timed chip-enable / strobe sequence that the
// expansion peripherals (UART etc.) respond to:
//
//   IDLE -> SETUP (SETUP_CYCLES) -> STROBE (STROBE_CYCLES) -> HOLD (HOLD_CYCLES)
//        -> IDLE with a one-cycle response pulse
//
// Read data is sampled on the last STROBE edge. If no device pulls i_busNOE
// low at that edge, NODEV_DATA is returned and o_rspNoDev is raised.
//
// Ports
//   oszClk       clock
//   resetn       asynchronous reset, active-high (legacy name)
//   i_reqValid   request present
//   o_reqReady   master idle; request taken when i_reqValid & o_reqReady
//   i_reqWrite   1 = write, 0 = read
//   i_reqAddr    IO address
//   i_reqWData   write data
//   o_rspValid   one-cycle pulse, transaction complete
//   o_rspData    read data (0 for writes)
//   o_rspNoDev   read was not answered (qualified by o_rspValid)
//   o_ioNCE      chip enable, active low
//   o_ioAddress  bus address
//   o_ioNOE      read strobe, active low
//   o_ioNWE      write strobe, active low
//   o_bus        write data towards the peripherals
//   o_busDrive   1 while the master drives o_bus
//   i_bus        read data from the peripherals
//   i_busNOE     a peripheral drives i_bus, active low
//
// Every output is a flop. The asynchronous reset releases all strobes and
// the bus driver immediately, so a reset in the middle of a transaction
// never leaves a peripheral selected or the bus contended.
// -----------------------------------------------------------------------------
module io_bus_master #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter logic [7:0]  NODEV_DATA    = 8'hFF
) (
  input  logic       oszClk,
  input  logic       resetn,
  input  logic       i_reqValid,
  output logic       o_reqReady,
  input  logic       i_reqWrite,
  input  logic [7:0] i_reqAddr,
  input  logic [7:0] i_reqWData,
  output logic       o_rspValid,
  output logic [7:0] o_rspData,
  output logic       o_rspNoDev,
  output logic       o_ioNCE,
  output logic [7:0] o_ioAddress,
  output logic       o_ioNOE,
  output logic       o_ioNWE,
  output logic [7:0] o_bus,
  output logic       o_busDrive,
  input  logic [7:0] i_bus,
  input  logic       i_busNOE
);

  // Counter reload values: a phase lasting N cycles counts N-1 down to 0.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES  - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES   - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_write;
  logic [7:0] r_rdData;
  logic       r_noDev;

  logic       w_accept;
  logic       w_cntZero;

  // o_reqReady is high exactly while the FSM sits in IDLE.
  assign w_accept  = i_reqValid & o_reqReady;
  assign w_cntZero = (r_cnt == 4'd0);

  always_ff @(posedge oszClk or posedge resetn) begin
    if (resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_rdData    <= 8'h00;
      r_noDev     <= 1'b0;
      o_reqReady  <= 1'b1;
      o_rspValid  <= 1'b0;
      o_rspData   <= 8'h00;
      o_rspNoDev  <= 1'b0;
      o_ioNCE     <= 1'b1;
      o_ioAddress <= 8'h00;
      o_ioNOE     <= 1'b1;
      o_ioNWE     <= 1'b1;
      o_bus       <= 8'h00;
      o_busDrive  <= 1'b0;
    end else begin
      // The response is a single-cycle pulse; only the HOLD exit raises it.
      o_rspValid <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_SETUP;
            r_cnt       <= SETUP_LD;
            r_write     <= i_reqWrite;
            o_reqReady  <= 1'b0;
            o_ioNCE     <= 1'b0;
            o_ioAddress <= i_reqAddr;
            // Write data goes on the bus together with the address so it is
            // stable for the whole setup time before NWE falls.
            o_bus       <= i_reqWrite ? i_reqWData : 8'h00;
            o_busDrive  <= i_reqWrite;
          end
        end

        ST_SETUP: begin
          if (w_cntZero) begin
            r_state <= ST_STROBE;
            r_cnt   <= STROBE_LD;
            // Exactly one strobe falls, selected by the latched direction.
            o_ioNOE <= r_write;
            o_ioNWE <= ~r_write;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_STROBE: begin
          if (w_cntZero) begin
            r_state <= ST_HOLD;
            r_cnt   <= HOLD_LD;
            o_ioNOE <= 1'b1;
            o_ioNWE <= 1'b1;
            // Last strobe edge: the only point where the read bus is looked at.
            if (r_write) begin
              r_rdData <= 8'h00;
              r_noDev  <= 1'b0;
            end else if (!i_busNOE) begin
              r_rdData <= i_bus;
              r_noDev  <= 1'b0;
            end else begin
              r_rdData <= NODEV_DATA;
              r_noDev  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_HOLD: begin
          if (w_cntZero) begin
            r_state    <= ST_IDLE;
            o_ioNCE    <= 1'b1;
            o_busDrive <= 1'b0;
            // Ready rises with the response so a waiting request is taken on
            // the next edge, leaving exactly one NCE-high cycle in between.
            o_reqReady <= 1'b1;
            o_rspValid <= 1'b1;
            o_rspData  <= r_rdData;
            o_rspNoDev <= r_noDev;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// -----------------------------------------------------------------------------
// tb_io_bus_master
//
// Bench for io_bus_master. Two instances share all inputs: u_dut uses the
// default timing (1/2/1), u_dut2 uses 2/3/2. The outputs of the instance
// under observation are selected by sel. Response data is checked through a
// scoreboard queue filled when a request is presented; bus timing is checked
// cycle by cycle against a timeline computed from the phase lengths.
// -----------------------------------------------------------------------------
module tb_io_bus_master;

  logic       oszClk;
  logic       resetn;
  logic       i_reqValid;
  logic       i_reqWrite;
  logic [7:0] i_reqAddr;
  logic [7:0] i_reqWData;
  logic [7:0] i_bus;
  logic       i_busNOE;

  logic       a_reqReady, a_rspValid, a_rspNoDev, a_ioNCE, a_ioNOE, a_ioNWE, a_busDrive;
  logic [7:0] a_rspData, a_ioAddress, a_bus;
  logic       b_reqReady, b_rspValid, b_rspNoDev, b_ioNCE, b_ioNOE, b_ioNWE, b_busDrive;
  logic [7:0] b_rspData, b_ioAddress, b_bus;

  logic       sel;
  logic       m_reqReady, m_rspValid, m_rspNoDev, m_ioNCE, m_ioNOE, m_ioNWE, m_busDrive;
  logic [7:0] m_rspData, m_ioAddress, m_bus;

  assign m_reqReady  = sel ? b_reqReady  : a_reqReady;
  assign m_rspValid  = sel ? b_rspValid  : a_rspValid;
  assign m_rspNoDev  = sel ? b_rspNoDev  : a_rspNoDev;
  assign m_rspData   = sel ? b_rspData   : a_rspData;
  assign m_ioNCE     = sel ? b_ioNCE     : a_ioNCE;
  assign m_ioNOE     = sel ? b_ioNOE     : a_ioNOE;
  assign m_ioNWE     = sel ? b_ioNWE     : a_ioNWE;
  assign m_ioAddress = sel ? b_ioAddress : a_ioAddress;
  assign m_bus       = sel ? b_bus       : a_bus;
  assign m_busDrive  = sel ? b_busDrive  : a_busDrive;

  io_bus_master u_dut (
    .oszClk(oszClk), .resetn(resetn),
    .i_reqValid(i_reqValid), .o_reqReady(a_reqReady), .i_reqWrite(i_reqWrite),
    .i_reqAddr(i_reqAddr), .i_reqWData(i_reqWData),
    .o_rspValid(a_rspValid), .o_rspData(a_rspData), .o_rspNoDev(a_rspNoDev),
    .o_ioNCE(a_ioNCE), .o_ioAddress(a_ioAddress), .o_ioNOE(a_ioNOE), .o_ioNWE(a_ioNWE),
    .o_bus(a_bus), .o_busDrive(a_busDrive), .i_bus(i_bus), .i_busNOE(i_busNOE)
  );

  io_bus_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2), .NODEV_DATA(8'hFF)) u_dut2 (
    .oszClk(oszClk), .resetn(resetn),
    .i_reqValid(i_reqValid), .o_reqReady(b_reqReady), .i_reqWrite(i_reqWrite),
    .i_reqAddr(i_reqAddr), .i_reqWData(i_reqWData),
    .o_rspValid(b_rspValid), .o_rspData(b_rspData), .o_rspNoDev(b_rspNoDev),
    .o_ioNCE(b_ioNCE), .o_ioAddress(b_ioAddress), .o_ioNOE(b_ioNOE), .o_ioNWE(b_ioNWE),
    .o_bus(b_bus), .o_busDrive(b_busDrive), .i_bus(i_bus), .i_busNOE(i_busNOE)
  );

  initial oszClk = 1'b0;
  always #5 oszClk = ~oszClk;

  typedef struct {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       dev;        // a device answers the read
    logic [7:0] rdata;      // value placed on i_bus during STROBE
    logic [7:0] exp_data;
    logic       exp_nodev;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       nd;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every response must match the oldest expectation.
  always @(negedge oszClk) begin
    if (!resetn && m_rspValid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rspValid with data %0h, no response outstanding", m_rspData);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rspData", {24'h0, m_rspData}, {24'h0, e.d});
        chk("rspNoDev", {31'h0, m_rspNoDev}, {31'h0, e.nd});
      end
    end
  end

  // Read-side stimulus: inside STROBE the vector's own answer; outside it the
  // opposite answer, so sampling at any other edge produces a wrong result.
  task automatic set_bus(input vec_t v, input bit in_strobe);
    if (in_strobe) begin
      i_busNOE = ~v.dev;
      i_bus    = v.rdata;
    end else begin
      i_busNOE = v.dev;
      i_bus    = ~v.rdata;
    end
  endtask

  // One transaction on the selected instance. presented=1 means the request
  // is already on the inputs from the previous call (back-to-back). While
  // busy the inputs carry nv with valid high; chain=1 keeps them valid in the
  // response cycle so nv is taken there.
  task automatic run_txn(input vec_t v, input bit presented, input bit chain,
                         input vec_t nv, input int S, input int T, input int H);
    int   L;
    bit   busy, strb;
    exp_t e;
    L = S + T + H;
    if (!presented) begin
      @(negedge oszClk);
      chk("ready_before_req", {31'h0, m_reqReady}, 32'h1);
      i_reqValid = 1'b1;
      i_reqWrite = v.write;
      i_reqAddr  = v.addr;
      i_reqWData = v.wdata;
      set_bus(v, 1'b0);
    end
    e.d  = v.exp_data;
    e.nd = v.exp_nodev;
    sb_q.push_back(e);
    @(posedge oszClk);
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge oszClk);
      busy = (c <= L);
      strb = (c >= S + 1) && (c <= S + T);
      chk($sformatf("NCE_c%0d_a%0h", c, v.addr), {31'h0, m_ioNCE}, {31'h0, ~busy});
      chk($sformatf("NOE_c%0d_a%0h", c, v.addr), {31'h0, m_ioNOE}, {31'h0, ~(~v.write & strb)});
      chk($sformatf("NWE_c%0d_a%0h", c, v.addr), {31'h0, m_ioNWE}, {31'h0, ~(v.write & strb)});
      chk($sformatf("busDrive_c%0d_a%0h", c, v.addr), {31'h0, m_busDrive}, {31'h0, v.write & busy});
      if (v.write && busy)
        chk($sformatf("bus_c%0d_a%0h", c, v.addr), {24'h0, m_bus}, {24'h0, v.wdata});
      chk($sformatf("addr_c%0d_a%0h", c, v.addr), {24'h0, m_ioAddress}, {24'h0, v.addr});
      chk($sformatf("ready_c%0d_a%0h", c, v.addr), {31'h0, m_reqReady}, {31'h0, ~busy});
      chk($sformatf("rspValid_c%0d_a%0h", c, v.addr), {31'h0, m_rspValid}, {31'h0, ~busy});
      i_reqWrite = nv.write;
      i_reqAddr  = nv.addr;
      i_reqWData = nv.wdata;
      if (busy) begin
        i_reqValid = 1'b1;
        set_bus(v, (c >= S + 1) && (c <= S + T));
      end else begin
        i_reqValid = chain;
        set_bus(nv, 1'b0);
      end
    end
  endtask

  localparam int DS = 1, DT = 2, DH = 1;
  localparam int NV = 6;
  vec_t tbl[NV];
  vec_t wa, wb, rd, ab;

  initial begin
    tbl[0] = '{1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'h11, 8'h00, 1'b1, 8'h3C, 8'h3C, 1'b0};
    tbl[2] = '{1'b0, 8'h20, 8'h00, 1'b0, 8'h42, 8'hFF, 1'b1};
    tbl[3] = '{1'b1, 8'h7F, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[4] = '{1'b0, 8'h80, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 8'hFF, 8'h5A, 1'b1, 8'h99, 8'h00, 1'b0};
    wa     = '{1'b1, 8'h21, 8'h11, 1'b0, 8'h00, 8'h00, 1'b0};
    wb     = '{1'b1, 8'h22, 8'hEE, 1'b0, 8'h00, 8'h00, 1'b0};
    rd     = '{1'b0, 8'h5C, 8'h00, 1'b1, 8'hC5, 8'hC5, 1'b0};
    ab     = '{1'b1, 8'h33, 8'hC3, 1'b0, 8'h00, 8'h00, 1'b0};

    sel        = 1'b0;
    resetn     = 1'b1;
    i_reqValid = 1'b0;
    i_reqWrite = 1'b0;
    i_reqAddr  = 8'h00;
    i_reqWData = 8'h00;
    i_bus      = 8'h00;
    i_busNOE   = 1'b1;

    // Reset state
    repeat (2) @(negedge oszClk);
    chk("rst_reqReady", {31'h0, m_reqReady}, 32'h1);
    chk("rst_rspValid", {31'h0, m_rspValid}, 32'h0);
    chk("rst_rspData", {24'h0, m_rspData}, 32'h0);
    chk("rst_rspNoDev", {31'h0, m_rspNoDev}, 32'h0);
    chk("rst_NCE", {31'h0, m_ioNCE}, 32'h1);
    chk("rst_NOE", {31'h0, m_ioNOE}, 32'h1);
    chk("rst_NWE", {31'h0, m_ioNWE}, 32'h1);
    chk("rst_addr", {24'h0, m_ioAddress}, 32'h0);
    chk("rst_bus", {24'h0, m_bus}, 32'h0);
    chk("rst_busDrive", {31'h0, m_busDrive}, 32'h0);
    resetn = 1'b0;
    repeat (2) @(negedge oszClk);

    // Table of single transactions, default timing
    for (int i = 0; i < NV; i++)
      run_txn(tbl[i], 1'b0, 1'b0, tbl[(i + 1) % NV], DS, DT, DH);

    // Back-to-back writes with valid held high
    run_txn(wa, 1'b0, 1'b1, wb, DS, DT, DH);
    run_txn(wb, 1'b1, 1'b0, wa, DS, DT, DH);

    // Reset during the STROBE of a write
    @(negedge oszClk);
    i_reqValid = 1'b1;
    i_reqWrite = ab.write;
    i_reqAddr  = ab.addr;
    i_reqWData = ab.wdata;
    @(posedge oszClk);
    @(negedge oszClk);
    i_reqValid = 1'b0;
    @(negedge oszClk);
    chk("abort_NWE_low", {31'h0, m_ioNWE}, 32'h0);
    #1 resetn = 1'b1;
    #1;
    chk("abort_NWE", {31'h0, m_ioNWE}, 32'h1);
    chk("abort_NCE", {31'h0, m_ioNCE}, 32'h1);
    chk("abort_busDrive", {31'h0, m_busDrive}, 32'h0);
    chk("abort_ready", {31'h0, m_reqReady}, 32'h1);
    repeat (2) @(negedge oszClk);
    resetn = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge oszClk);
      chk($sformatf("abort_noRsp_%0d", c), {31'h0, m_rspValid}, 32'h0);
    end
    run_txn(rd, 1'b0, 1'b0, wa, DS, DT, DH);

    // Longer timing on the second instance (both instances idle by now)
    repeat (12) @(negedge oszClk);
    sel = 1'b1;
    run_txn(rd, 1'b0, 1'b0, wa, 2, 3, 2);
    run_txn(tbl[5], 1'b0, 1'b0, rd, 2, 3, 2);

    repeat (3) @(negedge oszClk);
    chk("sb_drained", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
